// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encoding and sizing helper shared by alu_mc
package alu_pkg;

  // Single-cycle operations
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;

  // Iterative operations (prefix 2'b10; bit 1 selects divide, bit 0 selects the high/remainder word)
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step counter must hold the value DATA_WIDTH itself
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle shift-add multiplier and restoring divider
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi,
  output logic                  last_step
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_width(DATA_WIDTH);

  // hi_r: accumulator high half (mul) or partial remainder (div)
  // lo_r: multiplier shifting out (mul) or dividend shifting out / quotient shifting in (div)
  // opb_r: multiplicand (mul) or divisor (div)
  logic [W-1:0]  hi_r;
  logic [W-1:0]  lo_r;
  logic [W-1:0]  opb_r;
  logic          div_r;
  logic [CW-1:0] cnt;

  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;
  logic [W:0]    div_diff;
  logic          div_ge;
  logic [W-1:0]  hi_nx;
  logic [W-1:0]  lo_nx;

  assign mul_sum   = {1'b0, hi_r} + {1'b0, {W{lo_r[0]}} & opb_r};
  assign div_shift = {hi_r, lo_r[W-1]};
  assign div_diff  = div_shift - {1'b0, opb_r};
  assign div_ge    = (div_shift >= {1'b0, opb_r});

  // Next register contents for one step; on the final step these are the finished words
  always_comb begin
    hi_nx = mul_sum[W:1];
    lo_nx = {mul_sum[0], lo_r[W-1:1]};
    if (div_r) begin
      hi_nx = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
      lo_nx = {lo_r[W-2:0], div_ge};
    end
  end

  assign hi        = hi_nx;
  assign lo        = lo_nx;
  assign last_step = (cnt == CW'(1));

  // Load operands on start, then advance one bit per cycle until the counter drains
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      opb_r <= '0;
      div_r <= 1'b0;
    end else if (start) begin
      cnt   <= CW'(W);
      hi_r  <= '0;
      lo_r  <= a;
      opb_r <= b;
      div_r <= is_div;
    end else if (cnt != '0) begin
      cnt  <= cnt - CW'(1);
      hi_r <= hi_nx;
      lo_r <= lo_nx;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake and iterative mul/div
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  localparam int W = DATA_WIDTH;

  state_t       state;
  logic [3:0]   op_r;
  logic         iter_op;
  logic         start;
  logic [W-1:0] it_lo;
  logic [W-1:0] it_hi;
  logic [W-1:0] it_res;
  logic         last_step;

  logic [W:0]   add_full;
  logic [W:0]   sub_full;
  logic         add_ovf;
  logic         sub_ovf;
  logic         sub_borrow;
  logic [W-1:0] sc_res;
  logic         sc_ovf;
  logic         sc_cout;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign iter_op   = (ALUop[3:2] == 2'b10);
  assign start     = in_valid && in_ready && iter_op;

  muldiv_iter #(.DATA_WIDTH(W)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_div    (ALUop[1]),
    .a         (A),
    .b         (B),
    .lo        (it_lo),
    .hi        (it_hi),
    .last_step (last_step)
  );

  // MULHU and REMU take the high word, MUL and DIVU the low word
  assign it_res = op_r[0] ? it_hi : it_lo;

  assign add_full   = {1'b0, A} + {1'b0, B};
  assign sub_full   = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
  assign add_ovf    = (A[W-1] == B[W-1]) && (add_full[W-1] != A[W-1]);
  assign sub_ovf    = (A[W-1] != B[W-1]) && (sub_full[W-1] != A[W-1]);
  assign sub_borrow = ~sub_full[W];

  // Single-cycle result and flags; reserved and iterative codes fall to zero here
  always_comb begin
    sc_res  = '0;
    sc_ovf  = 1'b0;
    sc_cout = 1'b0;
    case (ALUop)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_NOR:  sc_res = ~(A | B);
      OP_ADD: begin
        sc_res  = add_full[W-1:0];
        sc_ovf  = add_ovf;
        sc_cout = add_full[W];
      end
      OP_SUB: begin
        sc_res  = sub_full[W-1:0];
        sc_ovf  = sub_ovf;
        sc_cout = sub_borrow;
      end
      OP_SLTU: sc_res = {{(W-1){1'b0}}, sub_borrow};
      OP_SLT:  sc_res = {{(W-1){1'b0}}, sub_full[W-1] ^ sub_ovf};
      default: sc_res = '0;
    endcase
  end

  // Handshake FSM; result and flags are registered only on the transition into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_r     <= '0;
      Result   <= '0;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
      Zero     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_r <= ALUop;
            if (iter_op) begin
              state <= ST_BUSY;
            end else begin
              Result   <= sc_res;
              Overflow <= sc_ovf;
              CarryOut <= sc_cout;
              Zero     <= (sc_res == '0);
              state    <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (last_step) begin
            Result   <= it_res;
            Overflow <= 1'b0;
            CarryOut <= 1'b0;
            Zero     <= (it_res == '0);
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized self-checking bench for alu_mc against a behavioural model
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Overflow;
  logic        CarryOut;
  logic        Zero;

  logic        w8_in_valid;
  logic        w8_in_ready;
  logic [7:0]  w8_a;
  logic [7:0]  w8_b;
  logic [3:0]  w8_op;
  logic        w8_out_valid;
  logic        w8_out_ready;
  logic [7:0]  w8_result;
  logic        w8_ovf;
  logic        w8_cout;
  logic        w8_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_mc #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUop     (ALUop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Overflow  (Overflow),
    .CarryOut  (CarryOut),
    .Zero      (Zero)
  );

  alu_mc #(.DATA_WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w8_in_valid),
    .in_ready  (w8_in_ready),
    .A         (w8_a),
    .B         (w8_b),
    .ALUop     (w8_op),
    .out_valid (w8_out_valid),
    .out_ready (w8_out_ready),
    .Result    (w8_result),
    .Overflow  (w8_ovf),
    .CarryOut  (w8_cout),
    .Zero      (w8_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definitions on 32-bit words
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov, output logic co);
    logic [32:0] t;
    logic [63:0] p;
    longint      s;
    r  = 32'd0;
    ov = 1'b0;
    co = 1'b0;
    p  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin
        t  = {1'b0, a} + {1'b0, b};
        r  = t[31:0];
        co = t[32];
        s  = longint'($signed(a)) + longint'($signed(b));
        ov = (s != longint'($signed(r)));
      end
      4'd3: r = (a < b) ? 32'd1 : 32'd0;
      4'd4: r = a ^ b;
      4'd5: r = ~(a | b);
      4'd6: begin
        r  = a - b;
        co = (a < b);
        s  = longint'($signed(a)) - longint'($signed(b));
        ov = (s != longint'($signed(r)));
      end
      4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: r = p[31:0];
      4'd9: r = p[63:32];
      4'd10: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request at a negedge in IDLE, then check latency, result, backpressure and handoff
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] got);
    logic [31:0] er;
    logic        eo;
    logic        ec;
    int          lat;
    int          exp_lat;
    logic        busy_bad;
    logic        hold_bad;
    model(op, a, b, er, eo, ec);
    exp_lat = (op[3:2] == 2'b10) ? 33 : 1;
    check($sformatf("in_ready_idle op%0d", op), in_ready, 1);
    in_valid = 1'b1;
    A = a;
    B = b;
    ALUop = op;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    ALUop = 4'($urandom);
    lat = 1;
    busy_bad = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check($sformatf("in_ready_busy op%0d", op), busy_bad, 0);
    check($sformatf("latency op%0d", op), lat, exp_lat);
    check($sformatf("result op%0d a=%0h b=%0h", op, a, b), Result, er);
    check($sformatf("overflow op%0d", op), Overflow, eo);
    check($sformatf("carryout op%0d", op), CarryOut, ec);
    check($sformatf("zero op%0d", op), Zero, (er == 0));
    got = Result;
    if (hold > 0) begin
      hold_bad = 1'b0;
      for (int k = 0; k < hold; k++) begin
        in_valid = ~in_valid;
        A = $urandom;
        B = $urandom;
        ALUop = 4'($urandom);
        @(negedge clk);
        if (Result !== er || Overflow !== eo || CarryOut !== ec || Zero !== (er == 0) ||
            in_ready !== 1'b0 || out_valid !== 1'b1)
          hold_bad = 1'b1;
      end
      check($sformatf("hold_stable op%0d", op), hold_bad, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("handoff op%0d", op), {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        stale;
    int          lat;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    ALUop = '0;
    w8_in_valid = 1'b0;
    w8_out_ready = 1'b0;
    w8_a = '0;
    w8_b = '0;
    w8_op = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", Result, 0);
    check("reset flags", {Overflow, CarryOut, Zero}, 3'b000);

    run_op(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 0, r);
    check("add_ovf const", {r, Overflow, CarryOut, Zero}, {32'h8000_0000, 3'b100});
    run_op(4'd6, 32'h0, 32'h1, 0, r);
    check("sub_borrow const", {r, Overflow, CarryOut}, {32'hFFFF_FFFF, 2'b01});
    run_op(4'd7, 32'h1, 32'hFFFF_FFFF, 0, r);
    check("slt const", r, 32'd0);
    run_op(4'd3, 32'h1, 32'hFFFF_FFFF, 0, r);
    check("sltu const", r, 32'd1);
    run_op(4'd6, 32'd5, 32'd5, 0, r);
    check("sub_zero const", Zero, 1);
    run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r);
    check("mul const", r, 32'h0000_0001);
    run_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r);
    check("mulhu const", r, 32'hFFFF_FFFE);
    run_op(4'd10, 32'd100, 32'd7, 0, r);
    check("divu const", r, 32'd14);
    run_op(4'd11, 32'd100, 32'd7, 0, r);
    check("remu const", r, 32'd2);
    run_op(4'd10, 32'd5, 32'd0, 0, r);
    check("divu_by0 const", r, 32'hFFFF_FFFF);
    run_op(4'd11, 32'd5, 32'd0, 0, r);
    check("remu_by0 const", r, 32'd5);
    run_op(4'd13, 32'h1234, 32'h5678, 0, r);
    check("reserved const", {r, Zero}, {32'd0, 1'b1});
    run_op(4'd2, 32'd40, 32'd2, 5, r);

    // Reset during the 10th BUSY cycle of a divide
    in_valid = 1'b1;
    A = 32'd100;
    B = 32'd7;
    ALUop = 4'd10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst ready/valid", {in_ready, out_valid}, 2'b10);
    check("midrst result", Result, 0);
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("midrst no_stale", stale, 0);
    run_op(4'd2, 32'd2, 32'd3, 0, r);
    check("post_rst add const", r, 32'd5);

    // Narrow instance: DIVU 200/3
    w8_in_valid = 1'b1;
    w8_a = 8'd200;
    w8_b = 8'd3;
    w8_op = 4'd10;
    @(posedge clk);
    @(negedge clk);
    w8_in_valid = 1'b0;
    lat = 1;
    while (!w8_out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("w8 divu latency", lat, 9);
    check("w8 divu result", w8_result, 8'd66);
    w8_out_ready = 1'b1;
    @(negedge clk);
    w8_out_ready = 1'b0;
    check("w8 handoff", {w8_in_ready, w8_out_valid}, 2'b10);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = pick();
      rb = ($urandom_range(0, 5) == 0) ? ra : pick();
      run_op(4'($urandom_range(0, 15)), ra, rb, int'($urandom_range(0, 2)), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
